// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between req0 (core WB) and req1 (long-latency WB); WB_ARB_RR_EN selects round-robin grant.
// Latency: write accepted at edge N is presented combinationally in cycle N+1 if granted. Backpressure: rdy drops when a FIFO holds FIFO_DEPTH entries.
module regfile_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int W     = 37,
   parameter int TAG_W = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic [W-1:0]           i_dat,
   input  logic                   i_pop,
   output logic [W-1:0]           o_head_dat,
   output logic [PTR_W:0]         o_count,
   output logic [DEPTH-1:0]       o_ent_vld,
   output logic [DEPTH*TAG_W-1:0] o_ent_tag
);
   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (i_push) mem_q[wr_ptr_q] <= i_dat;
      end
   end

   assign o_head_dat = mem_q[rd_ptr_q];
   assign o_count    = count_q;

   // An entry is live when its distance from the read pointer is below the count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [PTR_W-1:0] off;
      assign off                          = PTR_W'(g) - rd_ptr_q;
      assign o_ent_vld[g]                 = ({1'b0, off} < count_q);
      assign o_ent_tag[g*TAG_W +: TAG_W]  = mem_q[g][W-1 -: TAG_W];
   end
endmodule

module regfile_wb_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req0_vld,
   input  logic [4:0]  i_req0_rw,
   input  logic [31:0] i_req0_data,
   output logic        o_req0_rdy,
   input  logic        i_req1_vld,
   input  logic [4:0]  i_req1_rw,
   input  logic [31:0] i_req1_data,
   output logic        o_req1_rdy,
   input  logic [4:0]  i_ra,
   input  logic [4:0]  i_rb,
   output logic        o_regWr,
   output logic [4:0]  o_rw,
   output logic [31:0] o_busW,
   output logic        o_stall,
   output logic        o_busy
);
   typedef struct packed {
      logic [4:0]  rw;
      logic [31:0] data;
   } wb_ent_t;

   localparam int ENT_W = $bits(wb_ent_t);

   wb_ent_t                 head0, head1;
   logic [PTR_W:0]          cnt0, cnt1;
   logic [FIFO_DEPTH-1:0]   ent_vld0, ent_vld1;
   logic [FIFO_DEPTH*5-1:0] ent_tag0, ent_tag1;
   logic                    push0, push1;
   logic                    hv0, hv1;
   logic                    gnt0, gnt1;

   assign o_req0_rdy = (cnt0 != (PTR_W+1)'(FIFO_DEPTH));
   assign o_req1_rdy = (cnt1 != (PTR_W+1)'(FIFO_DEPTH));

   // Writes to r0 complete the handshake but are never queued.
   assign push0 = i_req0_vld & o_req0_rdy & (i_req0_rw != 5'd0);
   assign push1 = i_req1_vld & o_req1_rdy & (i_req1_rw != 5'd0);

   regfile_wb_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .W(ENT_W), .TAG_W(5)) u_fifo0 (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (push0),
      .i_dat      ({i_req0_rw, i_req0_data}),
      .i_pop      (gnt0),
      .o_head_dat (head0),
      .o_count    (cnt0),
      .o_ent_vld  (ent_vld0),
      .o_ent_tag  (ent_tag0)
   );

   regfile_wb_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .W(ENT_W), .TAG_W(5)) u_fifo1 (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (push1),
      .i_dat      ({i_req1_rw, i_req1_data}),
      .i_pop      (gnt1),
      .o_head_dat (head1),
      .o_count    (cnt1),
      .o_ent_vld  (ent_vld1),
      .o_ent_tag  (ent_tag1)
   );

   assign hv0 = (cnt0 != '0);
   assign hv1 = (cnt1 != '0);

`ifdef WB_ARB_RR_EN
   logic rr_q, rr_d;

   // rr_q selects the winner on contention; it always points away from the last winner.
   always_comb begin
      gnt0 = hv0;
      gnt1 = hv1;
      if (hv0 && hv1) begin
         gnt0 = ~rr_q;
         gnt1 = rr_q;
      end
      rr_d = rr_q;
      if (gnt0)      rr_d = 1'b1;
      else if (gnt1) rr_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rr_q <= 1'b0;
      else          rr_q <= rr_d;
   end
`else
   always_comb begin
      gnt0 = hv0;
      gnt1 = hv1 & ~hv0;
   end
`endif

   always_comb begin
      o_regWr = 1'b0;
      o_rw    = 5'd0;
      o_busW  = 32'd0;
      if (gnt0) begin
         o_regWr = 1'b1;
         o_rw    = head0.rw;
         o_busW  = head0.data;
      end else if (gnt1) begin
         o_regWr = 1'b1;
         o_rw    = head1.rw;
         o_busW  = head1.data;
      end
   end

   function automatic logic rd_hit(input logic [4:0] rw, input logic [4:0] ra, input logic [4:0] rb);
      return ((rw == ra) && (ra != 5'd0)) || ((rw == rb) && (rb != 5'd0));
   endfunction

   // The entry popped this cycle still stalls: the read happens before the edge that writes it.
   always_comb begin
      o_stall = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ent_vld0[i] && rd_hit(ent_tag0[i*5 +: 5], i_ra, i_rb)) o_stall = 1'b1;
         if (ent_vld1[i] && rd_hit(ent_tag1[i*5 +: 5], i_ra, i_rb)) o_stall = 1'b1;
      end
   end

   assign o_busy = hv0 | hv1;
endmodule
